rate_recovery_sequencer: RTL and testbench

Controller that sequences one `rate_recovery` instance through clear, acquisition, lock supervision and bounded retry.
- Drives that instance's `recovery_en_i` and `clear_state_i`.
- Watches its `locked_in_o`, `speed_change_detected_o`, bandpass flags and drift flags.
- Publishes a qualified rate with a valid flag to downstream clock-generation logic.
- Forces a clean re-acquisition whenever lock is lost, the rate changes, or violations accumulate.

---
 rtl/rate_recovery_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_rate_recovery_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_recovery_sequencer.sv
// Rate recovery sequencer: drives one rate_recovery instance through clear,
// acquisition, lock supervision and bounded retry, and publishes a qualified
// rate. Optional feature macro: RATE_RECOVERY_SEQUENCER_RATE_HOLD_EN keeps the
// last locked rate valid across relock cycles.
module rate_recovery_sequencer #(
    parameter int unsigned TIMER_WIDTH        = 16,
    parameter int unsigned RETRY_WIDTH        = 4,
    parameter int unsigned VIOL_WIDTH         = 8,
    parameter int unsigned CLEAR_CYCLES       = 2,
    parameter int unsigned RATE_COUNTER_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [TIMER_WIDTH-1:0]        acquire_timeout_i,
    input  logic [RETRY_WIDTH-1:0]        max_retries_i,
    input  logic [VIOL_WIDTH-1:0]         violation_limit_i,
    input  logic [TIMER_WIDTH-1:0]        leak_period_i,
    input  logic                          locked_in_i,
    input  logic                          speed_change_i,
    input  logic                          overshoot_i,
    input  logic                          undershoot_i,
    input  logic                          pos_drift_viol_i,
    input  logic                          neg_drift_viol_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] rate_i,
    output logic                          recovery_en_o,
    output logic                          clear_state_o,
    output logic                          rate_valid_o,
    output logic [RATE_COUNTER_WIDTH-1:0] rate_o,
    output logic                          fault_o,
    output logic [2:0]                    state_o,
    output logic [RETRY_WIDTH-1:0]        relock_count_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StAcquire = 3'd2,
        StLocked  = 3'd3,
        StFault   = 3'd4
    } state_e;

    localparam int unsigned ClrW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);
    // Headroom so add-then-leak can be computed before saturating.
    localparam int unsigned ViolW = VIOL_WIDTH + 3;
    localparam logic [ViolW-1:0] ViolMax = {3'b000, {VIOL_WIDTH{1'b1}}};

    state_e                  state_q, state_d;
    logic [ClrW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [TIMER_WIDTH-1:0]  acq_tmr_q, acq_tmr_d;
    logic [TIMER_WIDTH-1:0]  leak_tmr_q, leak_tmr_d;
    logic [RETRY_WIDTH-1:0]  retry_q, retry_d;
    logic [RETRY_WIDTH-1:0]  relock_q, relock_d;
    logic [VIOL_WIDTH-1:0]   viol_q, viol_d;

    logic                          clear_q, clear_d;
    logic                          rec_en_q, rec_en_d;
    logic                          valid_q, valid_d;
    logic [RATE_COUNTER_WIDTH-1:0] rate_q, rate_d;
    logic                          fault_q, fault_d;

    logic [2:0]              viol_cnt;
    logic                    leak_hit;
    logic [ViolW-1:0]        viol_sum;
    logic [VIOL_WIDTH-1:0]   viol_next;
    logic                    relock_trig;

    // Violation accumulator arithmetic: add this cycle's pulses, net the leak, saturate.
    always_comb begin
        viol_cnt = {2'b00, overshoot_i} + {2'b00, undershoot_i}
                 + {2'b00, pos_drift_viol_i} + {2'b00, neg_drift_viol_i};
        leak_hit = (leak_period_i != '0) && (leak_tmr_q == leak_period_i - TIMER_WIDTH'(1));
        viol_sum = {3'b000, viol_q} + ViolW'(viol_cnt);
        if (leak_hit && (viol_sum != '0)) begin
            viol_sum = viol_sum - ViolW'(1);
        end
        viol_next = (viol_sum > ViolMax) ? {VIOL_WIDTH{1'b1}} : viol_sum[VIOL_WIDTH-1:0];
        relock_trig = !locked_in_i || speed_change_i
                    || ((violation_limit_i != '0) && (viol_next >= violation_limit_i));
    end

    // Next-state and counter update; enable low overrides everything.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = '0;
        acq_tmr_d  = '0;
        leak_tmr_d = '0;
        viol_d     = '0;
        retry_d    = retry_q;
        relock_d   = relock_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d  = StClear;
                    retry_d  = '0;
                    relock_d = '0;
                end
            end
            StClear: begin
                if (clr_cnt_q == ClrLast) begin
                    state_d = StAcquire;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClrW'(1);
                end
            end
            StAcquire: begin
                if (locked_in_i) begin
                    state_d = StLocked;
                    retry_d = '0;
                end else if (acq_tmr_q == acquire_timeout_i) begin
                    if (retry_q < max_retries_i) begin
                        retry_d = retry_q + RETRY_WIDTH'(1);
                        state_d = StClear;
                    end else begin
                        state_d = StFault;
                    end
                end else begin
                    // Timer never passes the timeout, so this cannot wrap.
                    acq_tmr_d = acq_tmr_q + TIMER_WIDTH'(1);
                end
            end
            StLocked: begin
                viol_d = viol_next;
                if (leak_hit) begin
                    leak_tmr_d = '0;
                end else if (leak_tmr_q != '1) begin
                    leak_tmr_d = leak_tmr_q + TIMER_WIDTH'(1);
                end else begin
                    leak_tmr_d = leak_tmr_q;
                end
                if (relock_trig) begin
                    state_d = StClear;
                    viol_d  = '0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RETRY_WIDTH'(1);
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (!enable_i) begin
            state_d    = StIdle;
            clr_cnt_d  = '0;
            acq_tmr_d  = '0;
            leak_tmr_d = '0;
            viol_d     = '0;
            retry_d    = '0;
            relock_d   = '0;
        end
    end

`ifdef RATE_RECOVERY_SEQUENCER_RATE_HOLD_EN
    logic seen_q, seen_d;

    // Output next values; the last locked rate stays valid through relock cycles.
    always_comb begin
        clear_d  = (state_d == StClear);
        rec_en_d = (state_d == StAcquire) || (state_d == StLocked);
        fault_d  = (state_d == StFault);
        seen_d   = seen_q;
        valid_d  = 1'b0;
        rate_d   = '0;
        unique case (state_d)
            StLocked: begin
                seen_d  = 1'b1;
                valid_d = 1'b1;
                rate_d  = rate_i;
            end
            StClear, StAcquire: begin
                valid_d = seen_q;
                rate_d  = rate_q;
            end
            default: begin
                seen_d = 1'b0;
            end
        endcase
    end

    // Tracks whether a lock has occurred since leaving IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
`else
    // Output next values; rate is only published while locked.
    always_comb begin
        clear_d  = (state_d == StClear);
        rec_en_d = (state_d == StAcquire) || (state_d == StLocked);
        fault_d  = (state_d == StFault);
        valid_d  = (state_d == StLocked);
        rate_d   = (state_d == StLocked) ? rate_i : '0;
    end
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            clr_cnt_q  <= '0;
            acq_tmr_q  <= '0;
            leak_tmr_q <= '0;
            viol_q     <= '0;
            retry_q    <= '0;
            relock_q   <= '0;
            clear_q    <= 1'b0;
            rec_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            rate_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            acq_tmr_q  <= acq_tmr_d;
            leak_tmr_q <= leak_tmr_d;
            viol_q     <= viol_d;
            retry_q    <= retry_d;
            relock_q   <= relock_d;
            clear_q    <= clear_d;
            rec_en_q   <= rec_en_d;
            valid_q    <= valid_d;
            rate_q     <= rate_d;
            fault_q    <= fault_d;
        end
    end

    assign state_o        = state_q;
    assign clear_state_o  = clear_q;
    assign recovery_en_o  = rec_en_q;
    assign rate_valid_o   = valid_q;
    assign rate_o         = rate_q;
    assign fault_o        = fault_q;
    assign relock_count_o = relock_q;

endmodule

// File: tb/tb_rate_recovery_sequencer.sv
// Self-checking bench for rate_recovery_sequencer: a vector table for the
// main lock/relock flow plus hand-written multi-cycle sequences, all checked
// through an expected-output queue.
module tb_rate_recovery_sequencer;

    localparam int unsigned TW  = 16;
    localparam int unsigned RW  = 4;
    localparam int unsigned VW  = 8;
    localparam int unsigned CC  = 2;
    localparam int unsigned RCW = 16;
`ifdef RATE_RECOVERY_SEQUENCER_RATE_HOLD_EN
    localparam bit Hold = 1'b1;
`else
    localparam bit Hold = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, locked = 1'b0, speed = 1'b0;
    logic ov = 1'b0, un = 1'b0, pd = 1'b0, nd = 1'b0;
    logic [RCW-1:0] rate_in = '0;
    logic [TW-1:0] acq_to = '0, leak_per = '0;
    logic [RW-1:0] max_rt = '0;
    logic [VW-1:0] viol_lim = '0;

    logic rec_en_o, clr_o, valid_o, fault_o;
    logic [RCW-1:0] rate_o;
    logic [2:0] state_o;
    logic [RW-1:0] relock_o;

    rate_recovery_sequencer #(
        .TIMER_WIDTH(TW), .RETRY_WIDTH(RW), .VIOL_WIDTH(VW),
        .CLEAR_CYCLES(CC), .RATE_COUNTER_WIDTH(RCW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .acquire_timeout_i(acq_to), .max_retries_i(max_rt),
        .violation_limit_i(viol_lim), .leak_period_i(leak_per),
        .locked_in_i(locked), .speed_change_i(speed),
        .overshoot_i(ov), .undershoot_i(un),
        .pos_drift_viol_i(pd), .neg_drift_viol_i(nd),
        .rate_i(rate_in),
        .recovery_en_o(rec_en_o), .clear_state_o(clr_o),
        .rate_valid_o(valid_o), .rate_o(rate_o),
        .fault_o(fault_o), .state_o(state_o), .relock_count_o(relock_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]     st;
        logic           clr;
        logic           en;
        logic           valid;
        logic [RCW-1:0] rate;
        logic           fault;
        logic [RW-1:0]  relock;
    } out_t;

    typedef struct packed {
        logic en, locked, speed, ov, un, pd, nd;
        logic [RCW-1:0] rate;
    } in_t;

    typedef struct {
        string         name;
        in_t           in;
        logic [2:0]    st;
        logic [RW-1:0] relock;
    } vec_t;

    out_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic m_seen = 1'b0;
    logic [RCW-1:0] m_rate = '0;

    function automatic in_t mi(logic e, logic l, logic s, logic o, logic u, logic p, logic n,
                               logic [RCW-1:0] r);
        in_t x;
        x.en = e; x.locked = l; x.speed = s;
        x.ov = o; x.un = u; x.pd = p; x.nd = n; x.rate = r;
        return x;
    endfunction

    // Expected outputs for a given state; tracks the held rate for the hold build.
    function automatic out_t mk(logic [2:0] st, logic [RW-1:0] rl, logic [RCW-1:0] r);
        out_t o;
        o.st     = st;
        o.clr    = (st == 3'd1);
        o.en     = (st == 3'd2) || (st == 3'd3);
        o.fault  = (st == 3'd4);
        o.relock = rl;
        if (st == 3'd3) begin
            m_seen = 1'b1;
            m_rate = r;
        end else if (st == 3'd0 || st == 3'd4) begin
            m_seen = 1'b0;
            m_rate = '0;
        end
        o.valid = (st == 3'd3) || (Hold && m_seen && (st == 3'd1 || st == 3'd2));
        o.rate  = (st == 3'd3) ? r : ((Hold && (st == 3'd1 || st == 3'd2)) ? m_rate : '0);
        return o;
    endfunction

    task automatic check(input string name);
        out_t a, e;
        a.st = state_o; a.clr = clr_o; a.en = rec_en_o; a.valid = valid_o;
        a.rate = rate_o; a.fault = fault_o; a.relock = relock_o;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d clr=%0b en=%0b vld=%0b rate=%h flt=%0b rl=%0d, want st=%0d clr=%0b en=%0b vld=%0b rate=%h flt=%0b rl=%0d",
                         name, a.st, a.clr, a.en, a.valid, a.rate, a.fault, a.relock,
                         e.st, e.clr, e.en, e.valid, e.rate, e.fault, e.relock);
            end
        end
    endtask

    task automatic step(input string name, input in_t in, input logic [2:0] st,
                        input logic [RW-1:0] rl);
        {en, locked, speed, ov, un, pd, nd, rate_in} = in;
        exp_q.push_back(mk(st, rl, in.rate));
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic run(input string name, input in_t in, input logic [2:0] st,
                       input logic [RW-1:0] rl, input int n);
        for (int i = 0; i < n; i++) step(name, in, st, rl);
    endtask

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock, relock on speed change and on lock loss; limit 0 ignores violations.
        tbl[0]  = '{"en_clear1",  mi(1,0,0,0,0,0,0,16'h40), 3'd1, 4'd0};
        tbl[1]  = '{"clear2",     mi(1,0,0,0,0,0,0,16'h40), 3'd1, 4'd0};
        tbl[2]  = '{"acq0",       mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0};
        tbl[3]  = '{"acq1",       mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0};
        tbl[4]  = '{"acq2",       mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0};
        tbl[5]  = '{"acq3",       mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0};
        tbl[6]  = '{"acq4",       mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0};
        tbl[7]  = '{"lock",       mi(1,1,0,0,0,0,0,16'h40), 3'd3, 4'd0};
        tbl[8]  = '{"lock_viol0", mi(1,1,0,1,1,1,1,16'h41), 3'd3, 4'd0};
        tbl[9]  = '{"speed_chg",  mi(1,1,1,0,0,0,0,16'h41), 3'd1, 4'd1};
        tbl[10] = '{"reclear2",   mi(1,1,0,0,0,0,0,16'h41), 3'd1, 4'd1};
        tbl[11] = '{"reacq",      mi(1,1,0,0,0,0,0,16'h41), 3'd2, 4'd1};
        tbl[12] = '{"relock",     mi(1,1,0,0,0,0,0,16'h40), 3'd3, 4'd1};
        tbl[13] = '{"lock_lost",  mi(1,0,0,0,0,0,0,16'h40), 3'd1, 4'd2};
        tbl[14] = '{"disable",    mi(0,0,0,0,0,0,0,16'h40), 3'd0, 4'd0};

        acq_to = 16'd100; max_rt = 4'd2; viol_lim = 8'd0; leak_per = 16'd0;
        #12;
        exp_q.push_back(mk(3'd0, 4'd0, '0));
        check("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i].name, tbl[i].in, tbl[i].st, tbl[i].relock);

        // Three timed-out windows of 11 cycles, then FAULT until enable drops.
        acq_to = 16'd10; max_rt = 4'd2;
        for (int w = 0; w < 3; w++) begin
            run("to_clear", mi(1,0,0,0,0,0,0,16'h0), 3'd1, 4'd0, 2);
            run("to_acq",   mi(1,0,0,0,0,0,0,16'h0), 3'd2, 4'd0, 11);
        end
        run("to_fault", mi(1,0,0,0,0,0,0,16'h0), 3'd4, 4'd0, 3);
        step("fault_exit", mi(0,0,0,0,0,0,0,16'h0), 3'd0, 4'd0);

        // Timeout 0: lock in the timeout cycle wins; without lock it faults at once.
        acq_to = 16'd0; max_rt = 4'd0;
        run("z_clear", mi(1,0,0,0,0,0,0,16'h55), 3'd1, 4'd0, 2);
        step("z_acq",  mi(1,0,0,0,0,0,0,16'h55), 3'd2, 4'd0);
        step("z_lock_vs_to", mi(1,1,0,0,0,0,0,16'h55), 3'd3, 4'd0);
        step("z_idle", mi(0,0,0,0,0,0,0,16'h55), 3'd0, 4'd0);
        run("z_clear", mi(1,0,0,0,0,0,0,16'h55), 3'd1, 4'd0, 2);
        step("z_acq",  mi(1,0,0,0,0,0,0,16'h55), 3'd2, 4'd0);
        step("z_fault", mi(1,0,0,0,0,0,0,16'h55), 3'd4, 4'd0);
        step("z_idle", mi(0,0,0,0,0,0,0,16'h55), 3'd0, 4'd0);

        // A lock restores the full retry budget.
        acq_to = 16'd3; max_rt = 4'd1;
        run("r_clear", mi(1,0,0,0,0,0,0,16'h22), 3'd1, 4'd0, 2);
        run("r_acq",   mi(1,0,0,0,0,0,0,16'h22), 3'd2, 4'd0, 4);
        run("r_clear", mi(1,0,0,0,0,0,0,16'h22), 3'd1, 4'd0, 2);
        step("r_acq",  mi(1,0,0,0,0,0,0,16'h22), 3'd2, 4'd0);
        step("r_lock", mi(1,1,0,0,0,0,0,16'h22), 3'd3, 4'd0);
        step("r_speed", mi(1,1,1,0,0,0,0,16'h22), 3'd1, 4'd1);
        step("r_clear", mi(1,0,0,0,0,0,0,16'h22), 3'd1, 4'd1);
        run("r_acq",   mi(1,0,0,0,0,0,0,16'h22), 3'd2, 4'd1, 4);
        run("r_retry_clear", mi(1,0,0,0,0,0,0,16'h22), 3'd1, 4'd1, 2);
        run("r_acq",   mi(1,0,0,0,0,0,0,16'h22), 3'd2, 4'd1, 4);
        step("r_fault", mi(1,0,0,0,0,0,0,16'h22), 3'd4, 4'd1);
        step("r_idle", mi(0,0,0,0,0,0,0,16'h22), 3'd0, 4'd0);

        // Violation accumulation with and without leak.
        acq_to = 16'd100; max_rt = 4'd2; viol_lim = 8'd4; leak_per = 16'd0;
        run("v_clear", mi(1,0,0,0,0,0,0,16'h40), 3'd1, 4'd0, 2);
        step("v_acq",  mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd0);
        step("v_lock", mi(1,1,0,0,0,0,0,16'h40), 3'd3, 4'd0);
        step("v_pulse1", mi(1,1,0,1,0,1,0,16'h40), 3'd3, 4'd0);
        step("v_pulse2", mi(1,1,0,1,0,1,0,16'h40), 3'd1, 4'd1);
        leak_per = 16'd1;
        step("v_clear", mi(1,1,0,0,0,0,0,16'h40), 3'd1, 4'd1);
        step("v_acq",  mi(1,1,0,0,0,0,0,16'h40), 3'd2, 4'd1);
        step("v_lock", mi(1,1,0,0,0,0,0,16'h40), 3'd3, 4'd1);
        for (int i = 0; i < 8; i++) begin
            step("leak_single", mi(1,1,0,(i%4)==0,(i%4)==1,(i%4)==2,(i%4)==3,16'h40),
                 3'd3, 4'd1);
        end
        run("leak_double", mi(1,1,0,1,1,0,0,16'h40), 3'd3, 4'd1, 3);
        step("leak_relock", mi(1,1,0,1,1,0,0,16'h40), 3'd1, 4'd2);

        // Enable dropped mid-ACQUIRE.
        viol_lim = 8'd0; leak_per = 16'd0;
        step("e_clear", mi(1,0,0,0,0,0,0,16'h40), 3'd1, 4'd2);
        step("e_acq",   mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd2);
        step("e_acq",   mi(1,0,0,0,0,0,0,16'h40), 3'd2, 4'd2);
        step("e_drop",  mi(0,0,0,0,0,0,0,16'h40), 3'd0, 4'd0);

        // Asynchronous reset while LOCKED.
        run("a_clear", mi(1,0,0,0,0,0,0,16'h77), 3'd1, 4'd0, 2);
        step("a_acq",  mi(1,0,0,0,0,0,0,16'h77), 3'd2, 4'd0);
        step("a_lock", mi(1,1,0,0,0,0,0,16'h77), 3'd3, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(3'd0, 4'd0, '0));
        check("async_reset");
        #1;
        rst_n = 1'b1;
        step("post_reset", mi(0,0,0,0,0,0,0,16'h77), 3'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
